// File: rtl/qc_ldpc_bitflip_decoder.sv
// Hard-decision bit-flipping decoder for the QC-LDPC code: walks the prototype ROM
// once per pass to build the syndrome, again to count unsatisfied checks, then flips.
module qc_ldpc_bitflip_decoder #(
    parameter int Z               = 54,
    parameter int NUM_INFO_BLKS   = 20,
    parameter int NUM_PARITY_BLKS = 4,
    parameter int TOTAL_BLKS      = NUM_INFO_BLKS + NUM_PARITY_BLKS,
    parameter int MAX_ITER        = 8,
    parameter int FLIP_TH         = 2,
    parameter int SW              = $clog2(Z) + 1,
    parameter int D               = NUM_PARITY_BLKS * TOTAL_BLKS,
    parameter int AW              = $clog2(D),
    parameter int ITW             = $clog2(MAX_ITER + 1)
) (
    input  logic                      CLK,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [TOTAL_BLKS*Z-1:0]   in_cw,
    output logic [AW-1:0]             rom_addr,
    input  logic [SW-1:0]             rom_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [TOTAL_BLKS*Z-1:0]   out_cw,
    output logic                      dec_ok,
    output logic [ITW-1:0]            iter_cnt
);
    localparam int R    = NUM_PARITY_BLKS;
    localparam int C    = TOTAL_BLKS;
    localparam int CNTW = $clog2(R + 1);
    localparam int RIW  = (R > 1) ? $clog2(R) : 1;
    localparam int CIW  = (C > 1) ? $clog2(C) : 1;
    localparam int PW   = $clog2(D + 1);

    typedef enum logic [2:0] {IDLE, SYND, CHECK, COUNT, FLIP, DONE} state_t;

    state_t                          state;
    logic [C-1:0][Z-1:0]             cw;
    logic [R-1:0][Z-1:0]             synd;
    logic [C-1:0][Z-1:0][CNTW-1:0]   bcnt;
    logic [C-1:0][Z-1:0]             flips;
    logic [PW-1:0]                   step;
    logic [RIW-1:0]                  r_cur, r_prv;
    logic [CIW-1:0]                  c_cur, c_prv;
    logic [SW-2:0]                   sh;
    logic [Z-1:0]                    rot_l, rot_r;
    logic                            take, walk_last, synd_zero, any_flip;

    function automatic logic [Z-1:0] rotl(input logic [Z-1:0] x, input logic [SW-2:0] s);
        return (x << s) | (x >> (Z - int'(s)));
    endfunction

    function automatic logic [Z-1:0] rotr(input logic [Z-1:0] x, input logic [SW-2:0] s);
        return (x >> s) | (x << (Z - int'(s)));
    endfunction

    // rom_data answers the address issued one cycle earlier, tracked by r_prv/c_prv
    assign sh        = rom_data[SW-2:0];
    assign take      = (step != '0) && !rom_data[SW-1];
    assign walk_last = (step == PW'(D));
    assign rot_l     = rotl(cw[c_prv], sh);
    assign rot_r     = rotr(synd[r_prv], sh);
    assign synd_zero = ~|synd;
    assign any_flip  = |flips;
    assign out_cw    = cw;

    for (genvar c = 0; c < C; c++) begin : g_blk
        for (genvar j = 0; j < Z; j++) begin : g_bit
            assign flips[c][j] = (bcnt[c][j] >= CNTW'(FLIP_TH));
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            dec_ok    <= 1'b0;
            iter_cnt  <= '0;
            cw        <= '0;
            synd      <= '0;
            bcnt      <= '0;
            rom_addr  <= '0;
            step      <= '0;
            r_cur     <= '0;
            c_cur     <= '0;
            r_prv     <= '0;
            c_prv     <= '0;
        end else begin
            r_prv <= r_cur;
            c_prv <= c_cur;
            if (state == SYND || state == COUNT) begin
                if (!walk_last) step <= step + PW'(1);
                if (step < PW'(D - 1)) begin
                    rom_addr <= rom_addr + AW'(1);
                    if (c_cur == CIW'(C - 1)) begin
                        c_cur <= '0;
                        r_cur <= r_cur + RIW'(1);
                    end else begin
                        c_cur <= c_cur + CIW'(1);
                    end
                end
            end
            case (state)
                IDLE: if (in_valid) begin
                    cw       <= in_cw;
                    iter_cnt <= '0;
                    dec_ok   <= 1'b0;
                    in_ready <= 1'b0;
                    synd     <= '0;
                    step     <= '0;
                    rom_addr <= '0;
                    r_cur    <= '0;
                    c_cur    <= '0;
                    state    <= SYND;
                end
                SYND: begin
                    if (take) synd[r_prv] <= synd[r_prv] ^ rot_l;
                    if (walk_last) state <= CHECK;
                end
                CHECK: begin
                    if (synd_zero || iter_cnt == ITW'(MAX_ITER)) begin
                        dec_ok    <= synd_zero;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        bcnt     <= '0;
                        step     <= '0;
                        rom_addr <= '0;
                        r_cur    <= '0;
                        c_cur    <= '0;
                        state    <= COUNT;
                    end
                end
                COUNT: begin
                    if (take) begin
                        for (int j = 0; j < Z; j++)
                            if (rot_r[j] && bcnt[c_prv][j] != CNTW'(R))
                                bcnt[c_prv][j] <= bcnt[c_prv][j] + CNTW'(1);
                    end
                    if (walk_last) state <= FLIP;
                end
                FLIP: begin
                    cw       <= cw ^ flips;
                    iter_cnt <= iter_cnt + ITW'(1);
                    if (any_flip) begin
                        synd     <= '0;
                        step     <= '0;
                        rom_addr <= '0;
                        r_cur    <= '0;
                        c_cur    <= '0;
                        state    <= SYND;
                    end else begin
                        // nothing crosses the threshold: further passes cannot change anything
                        dec_ok    <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qc_ldpc_bitflip_decoder.sv
// Scoreboard bench for qc_ldpc_bitflip_decoder: driver pushes expected results,
// a negedge monitor pops and compares whenever out_valid rises.
module tb_qc_ldpc_bitflip_decoder;
    localparam int Z = 54, NI = 20, NP = 4, C = NI + NP, R = NP, D = R * C;
    localparam int MAXIT = 8, N = C * Z;
    localparam int LAT0 = D + 3, LATIT = 2 * D + 4;

    logic           CLK = 1'b0;
    logic           rst_n, in_valid, in_ready, out_valid, out_ready, dec_ok;
    logic [N-1:0]   in_cw, out_cw;
    logic [6:0]     rom_addr, rom_data;
    logic [3:0]     iter_cnt;

    qc_ldpc_bitflip_decoder #(.Z(Z), .NUM_INFO_BLKS(NI), .NUM_PARITY_BLKS(NP),
                              .MAX_ITER(MAXIT), .FLIP_TH(2)) dut (
        .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_cw(in_cw), .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_cw(out_cw),
        .dec_ok(dec_ok), .iter_cnt(iter_cnt));

    always #5 CLK = ~CLK;

    logic [6:0] rom [0:D-1];
    always @(posedge CLK) rom_data <= rom[rom_addr];

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] cw;
        logic         ok;
        logic [3:0]   it;
        int           lat;
        int           acc;
    } exp_t;
    exp_t exp_q[$];

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic chk_cw(input string nm, input logic [N-1:0] act, input logic [N-1:0] req);
        int b;
        n_tests++;
        if (act !== req) begin
            b = 0;
            for (int i = C - 1; i >= 0; i--) if (act[i*Z +: Z] !== req[i*Z +: Z]) b = i;
            n_fail++;
            $display("FAIL %s: block %0d got %h, required %h", nm, b, act[b*Z +: Z], req[b*Z +: Z]);
        end
    endtask

    // kind 0: all shift 0; 1: r*c with row 3 only at cols 0,3; 2: kind 1 with col 0 = Z-1-r; 3: row 0 only
    task automatic load_rom(input int kind);
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                logic [6:0] v;
                case (kind)
                    0: v = 7'd0;
                    3: v = (r == 0) ? 7'd0 : 7'h40;
                    default: v = (r < 3 || c == 0 || c == 3) ? 7'((r * c) % Z) : 7'h40;
                endcase
                if (kind == 2 && c == 0) v = 7'(Z - 1 - r);
                assert (v[6] || v[5:0] < 6'(Z)) else $error("illegal shift at %0d,%0d", r, c);
                rom[r*C + c] = v;
            end
        end
    endtask

    logic ov_q = 1'b0;
    always @(negedge CLK) begin
        exp_t e;
        if (rst_n && out_valid && !ov_q) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got out_valid 1, required no pending result");
            end else begin
                e = exp_q.pop_front();
                chk_cw("out_cw", out_cw, e.cw);
                chk("dec_ok", 64'(dec_ok), 64'(e.ok));
                chk("iter_cnt", 64'(iter_cnt), 64'(e.it));
                chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
            end
        end
        ov_q <= out_valid;
    end

    task automatic decode(input logic [N-1:0] cw, input logic [N-1:0] ecw, input logic eok,
                          input int eit, input int elat, input bit hold);
        exp_t e;
        int   t;
        @(negedge CLK);
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        out_ready = !hold;
        in_cw     = cw;
        in_valid  = 1'b1;
        @(posedge CLK);
        #1;
        e.cw = ecw; e.ok = eok; e.it = 4'(eit); e.lat = elat; e.acc = cyc;
        exp_q.push_back(e);
        @(negedge CLK);
        in_valid = 1'b0;
        chk("in_ready_busy", 64'(in_ready), 64'd0);
        t = 0;
        while (!out_valid && t < 5000) begin
            @(negedge CLK);
            t++;
        end
        if (!out_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL out_valid_timeout: got no result after %0d cycles, required one", t);
            return;
        end
        chk("rom_addr_hold", 64'(rom_addr), 64'(D - 1));
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge CLK);
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_in_ready", 64'(in_ready), 64'd0);
                chk("hold_dec_ok", 64'(dec_ok), 64'(eok));
                chk_cw("hold_out_cw", out_cw, ecw);
                if (i == 2) begin in_cw = ~cw; in_valid = 1'b1; end
                if (i == 3) in_valid = 1'b0;
            end
            out_ready = 1'b1;
        end
        @(negedge CLK);
        chk("post_out_valid", 64'(out_valid), 64'd0);
        chk("post_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] zero, p2, e3, e4, w40, e6;
        logic [Z-1:0] pat;
        zero = '0;
        pat  = 54'h2ABCDEF0123456;
        p2 = '0;  p2[0 +: Z] = pat;  p2[Z +: Z] = pat;
        e3 = '0;  e3[3*Z + 7] = 1'b1;
        e4 = '0;  e4[0] = 1'b1;
        w40 = '0; w40[39:0] = '1;
        e6 = '0;  e6[5] = 1'b1;

        rst_n = 1'b0; in_valid = 1'b0; in_cw = '0; out_ready = 1'b1;
        load_rom(0);
        repeat (3) @(negedge CLK);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_dec_ok", 64'(dec_ok), 64'd0);
        chk("rst_iter_cnt", 64'(iter_cnt), 64'd0);
        chk("rst_rom_addr", 64'(rom_addr), 64'd0);
        chk_cw("rst_out_cw", out_cw, zero);
        rst_n = 1'b1;

        decode(zero, zero, 1'b1, 0, LAT0, 1'b0);
        decode(p2, p2, 1'b1, 0, LAT0, 1'b0);
        load_rom(1);
        decode(e3, zero, 1'b1, 1, LAT0 + LATIT, 1'b0);
        load_rom(2);
        decode(e4, zero, 1'b1, 1, LAT0 + LATIT, 1'b0);
        // identical rows: each flip hits every block, so the pattern oscillates until the cap
        load_rom(0);
        decode(w40, w40, 1'b0, MAXIT, LAT0 + MAXIT * LATIT, 1'b0);
        load_rom(3);
        decode(e6, e6, 1'b0, 1, 2 * D + 5, 1'b0);
        load_rom(0);
        decode(zero, zero, 1'b1, 0, LAT0, 1'b1);

        // abort in the middle of COUNT
        @(negedge CLK);
        in_cw = w40; in_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        repeat (D + 10) @(negedge CLK);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_iter_cnt", 64'(iter_cnt), 64'd0);
        @(negedge CLK);
        rst_n = 1'b1;
        decode(p2, p2, 1'b1, 0, LAT0, 1'b0);

        repeat (5) @(negedge CLK);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
